// File: rtl/decode_stage.sv
// RV32I decode stage: latches fetch's PC/instruction, decodes it into a pipeline register for execute,
// and inserts a one-cycle bubble on a load-use hazard.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_ce,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_ex_is_load,
    input  logic        i_ex_ce,
    input  logic [4:0]  i_ex_rd,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_imm,
    output logic [2:0]  o_funct3,
    output logic [3:0]  o_alu_op,
    output logic [10:0] o_opcode,
    output logic        o_illegal,
    output logic        o_ecall,
    output logic        o_ebreak,
    output logic        o_mret,
    output logic        o_ce,
    output logic        o_stall
);
    localparam int OPC_LUI    = 0;
    localparam int OPC_AUIPC  = 1;
    localparam int OPC_JAL    = 2;
    localparam int OPC_JALR   = 3;
    localparam int OPC_BRANCH = 4;
    localparam int OPC_LOAD   = 5;
    localparam int OPC_STORE  = 6;
    localparam int OPC_OPIMM  = 7;
    localparam int OPC_OP     = 8;
    localparam int OPC_FENCE  = 9;
    localparam int OPC_SYSTEM = 10;

    localparam logic [10:0] RS1_UNUSED = 11'b000_0000_0111;
    localparam logic [10:0] RS2_USED   = 11'b001_0101_0000;
    localparam logic [10:0] RD_UNUSED  = 11'b010_0101_0000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NEQ  = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [10:0] d_opcode;
    logic        d_illegal;
    logic [3:0]  d_alu;
    logic [31:0] d_imm;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        d_ecall, d_ebreak, d_mret;
    logic        rs1_used, rs2_used, hazard, stall_any;

    assign opc = i_instr[6:0];
    assign f3  = i_instr[14:12];
    assign f7  = i_instr[31:25];

    assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_u = {i_instr[31:12], 12'b0};
    assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    assign d_ecall  = (i_instr == 32'h0000_0073);
    assign d_ebreak = (i_instr == 32'h0010_0073);
    assign d_mret   = (i_instr == 32'h3020_0073);

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // A full 7-bit match also rejects anything whose low two bits are not 2'b11.
    always_comb begin
        d_opcode  = '0;
        d_illegal = 1'b0;
        d_alu     = ALU_ADD;
        d_imm     = '0;
        case (opc)
            7'b0110111: begin d_opcode[OPC_LUI]   = 1'b1; d_imm = imm_u; end
            7'b0010111: begin d_opcode[OPC_AUIPC] = 1'b1; d_imm = imm_u; end
            7'b1101111: begin d_opcode[OPC_JAL]   = 1'b1; d_imm = imm_j; end
            7'b1100111: begin d_opcode[OPC_JALR]  = 1'b1; d_imm = imm_i; end
            7'b0000011: begin d_opcode[OPC_LOAD]  = 1'b1; d_imm = imm_i; end
            7'b0100011: begin d_opcode[OPC_STORE] = 1'b1; d_imm = imm_s; end
            7'b0001111: begin d_opcode[OPC_FENCE] = 1'b1; d_imm = imm_i; end
            7'b1100011: begin
                d_opcode[OPC_BRANCH] = 1'b1;
                d_imm                = imm_b;
                case (f3)
                    3'b000:  d_alu = ALU_EQ;
                    3'b001:  d_alu = ALU_NEQ;
                    3'b100:  d_alu = ALU_SLT;
                    3'b101:  d_alu = ALU_GE;
                    3'b110:  d_alu = ALU_SLTU;
                    3'b111:  d_alu = ALU_GEU;
                    default: d_alu = ALU_ADD;
                endcase
            end
            7'b0010011: begin
                d_opcode[OPC_OPIMM] = 1'b1;
                d_imm               = imm_i;
                d_alu               = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
                if ((f3 == 3'b001) && (f7 != 7'h00))
                    d_illegal = 1'b1;
                if ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20))
                    d_illegal = 1'b1;
            end
            7'b0110011: begin
                d_opcode[OPC_OP] = 1'b1;
                d_alu            = alu_from_funct3(f3, f7[5]);
                if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)))))
                    d_illegal = 1'b1;
            end
            7'b1110011: begin
                d_opcode[OPC_SYSTEM] = 1'b1;
                d_imm                = imm_i;
                if ((f3 == 3'b000) && !(d_ecall || d_ebreak || d_mret))
                    d_illegal = 1'b1;
                if (f3 == 3'b100)
                    d_illegal = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    assign d_rs1 = |(d_opcode & RS1_UNUSED) ? 5'd0 : i_instr[19:15];
    assign d_rs2 = |(d_opcode & RS2_USED)   ? i_instr[24:20] : 5'd0;
    assign d_rd  = |(d_opcode & RD_UNUSED)  ? 5'd0 : i_instr[11:7];

    assign rs1_used  = |(o_opcode & ~RS1_UNUSED);
    assign rs2_used  = |(o_opcode & RS2_USED);
    assign hazard    = o_ce && i_ex_ce && i_ex_is_load && (i_ex_rd != 5'd0) &&
                       (((i_ex_rd == o_rs1_addr) && rs1_used) || ((i_ex_rd == o_rs2_addr) && rs2_used));
    assign stall_any = i_stall || hazard;
    // Gated by reset so the stall request also reads zero while reset is held.
    assign o_stall   = !rst && stall_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pc       <= '0;
            o_rs1_addr <= '0;
            o_rs2_addr <= '0;
            o_rd_addr  <= '0;
            o_imm      <= '0;
            o_funct3   <= '0;
            o_alu_op   <= '0;
            o_opcode   <= '0;
            o_illegal  <= 1'b0;
            o_ecall    <= 1'b0;
            o_ebreak   <= 1'b0;
            o_mret     <= 1'b0;
            o_ce       <= 1'b0;
        end else begin
            if (i_ce && !stall_any) begin
                o_pc       <= i_pc;
                o_rs1_addr <= d_rs1;
                o_rs2_addr <= d_rs2;
                o_rd_addr  <= d_rd;
                o_imm      <= d_imm;
                o_funct3   <= f3;
                o_alu_op   <= d_alu;
                o_opcode   <= d_opcode;
                o_illegal  <= d_illegal;
                o_ecall    <= d_ecall;
                o_ebreak   <= d_ebreak;
                o_mret     <= d_mret;
            end
            // A flush only takes effect once no stall is pending; a hazard alone drops the entry as a bubble.
            if (!stall_any)
                o_ce <= i_flush ? 1'b0 : i_ce;
            else if (hazard && !i_stall)
                o_ce <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: hand-decoded expectations are queued as instructions are driven
// and compared when execute accepts an entry (o_ce high, no stall).
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_pc = '0, i_instr = '0;
    logic        i_ce = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
    logic        i_ex_is_load = 1'b0, i_ex_ce = 1'b0;
    logic [4:0]  i_ex_rd = '0;
    logic [31:0] o_pc, o_imm;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [2:0]  o_funct3;
    logic [3:0]  o_alu_op;
    logic [10:0] o_opcode;
    logic        o_illegal, o_ecall, o_ebreak, o_mret, o_ce, o_stall;

    typedef struct {
        logic [31:0] pc;
        logic [10:0] opcode;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        ill, ec, eb, mr, full;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .i_pc(i_pc), .i_instr(i_instr), .i_ce(i_ce),
        .i_stall(i_stall), .i_flush(i_flush), .i_ex_is_load(i_ex_is_load),
        .i_ex_ce(i_ex_ce), .i_ex_rd(i_ex_rd), .o_pc(o_pc), .o_rs1_addr(o_rs1_addr),
        .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr), .o_imm(o_imm), .o_funct3(o_funct3),
        .o_alu_op(o_alu_op), .o_opcode(o_opcode), .o_illegal(o_illegal), .o_ecall(o_ecall),
        .o_ebreak(o_ebreak), .o_mret(o_mret), .o_ce(o_ce), .o_stall(o_stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [10:0] opcode, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [3:0] alu, input logic ill,
                                input logic ec, input logic eb, input logic mr, input logic full);
        exp_t e;
        e.pc = '0; e.opcode = opcode; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.f3 = f3; e.alu = alu; e.ill = ill; e.ec = ec; e.eb = eb; e.mr = mr; e.full = full;
        return e;
    endfunction

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic push, input exp_t e);
        exp_t q;
        q = e;
        q.pc = pc;
        i_pc = pc;
        i_instr = instr;
        i_ce = 1'b1;
        if (push)
            sbq.push_back(q);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Execute accepts an entry on any cycle where decode presents it and nothing stalls.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_ce && !o_stall) begin
            if (sbq.size() == 0) begin
                checkOutput("sb_underflow", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                checkOutput("pc", o_pc, e.pc);
                checkOutput("illegal", {31'b0, o_illegal}, {31'b0, e.ill});
                checkOutput("ecall", {31'b0, o_ecall}, {31'b0, e.ec});
                checkOutput("ebreak", {31'b0, o_ebreak}, {31'b0, e.eb});
                checkOutput("mret", {31'b0, o_mret}, {31'b0, e.mr});
                if (e.full) begin
                    checkOutput("opcode", {21'b0, o_opcode}, {21'b0, e.opcode});
                    checkOutput("imm", o_imm, e.imm);
                    checkOutput("rs1", {27'b0, o_rs1_addr}, {27'b0, e.rs1});
                    checkOutput("rs2", {27'b0, o_rs2_addr}, {27'b0, e.rs2});
                    checkOutput("rd", {27'b0, o_rd_addr}, {27'b0, e.rd});
                    checkOutput("funct3", {29'b0, o_funct3}, {29'b0, e.f3});
                    checkOutput("alu_op", {28'b0, o_alu_op}, {28'b0, e.alu});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t eAddi, eBgeu, eSllBad, eEcall, eLui, eSw, eSrai, eJal, eLw, eZero, eMret, eAdd, eNone;
        eAddi   = mk(11'h080, 32'hFFFF_FFE0, 5'd2, 5'd0, 5'd2, 3'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eBgeu   = mk(11'h010, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd0, 3'd7, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eSllBad = mk(11'h000, 32'h0,         5'd0, 5'd0, 5'd0, 3'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        eEcall  = mk(11'h400, 32'h0,         5'd0, 5'd0, 5'd0, 3'd0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        eLui    = mk(11'h001, 32'h1234_5000, 5'd0, 5'd0, 5'd7, 3'd5, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eSw     = mk(11'h040, 32'h0000_0008, 5'd2, 5'd5, 5'd0, 3'd2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eSrai   = mk(11'h080, 32'h0000_0403, 5'd4, 5'd0, 5'd3, 3'd5, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eJal    = mk(11'h004, 32'h0000_0010, 5'd0, 5'd0, 5'd1, 3'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eLw     = mk(11'h020, 32'h0000_0004, 5'd1, 5'd0, 5'd5, 3'd2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eZero   = mk(11'h000, 32'h0,         5'd0, 5'd0, 5'd0, 3'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        eMret   = mk(11'h400, 32'h0000_0302, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        eAdd    = mk(11'h100, 32'h0,         5'd5, 5'd1, 5'd6, 3'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        eNone   = eZero;

        // Reset state, with i_stall high to show the stall request is masked.
        #1 rst = 1'b1;
        i_stall = 1'b1;
        repeat (2) tick();
        checkOutput("rst_ce", {31'b0, o_ce}, 32'd0);
        checkOutput("rst_stall", {31'b0, o_stall}, 32'd0);
        checkOutput("rst_pc", o_pc, 32'd0);
        checkOutput("rst_opcode", {21'b0, o_opcode}, 32'd0);
        checkOutput("rst_imm", o_imm, 32'd0);
        i_stall = 1'b0;
        rst = 1'b0;

        // Straight-line decode of a mix of formats.
        applyStimulus(32'h100, 32'hFE01_0113, 1'b1, eAddi);   tick();
        checkOutput("latency_ce", {31'b0, o_ce}, 32'd1);
        applyStimulus(32'h104, 32'hFE20_FEE3, 1'b1, eBgeu);   tick();
        applyStimulus(32'h108, 32'h4000_1033, 1'b1, eSllBad); tick();
        applyStimulus(32'h10C, 32'h0000_0073, 1'b1, eEcall);  tick();
        applyStimulus(32'h110, 32'h1234_53B7, 1'b1, eLui);    tick();
        applyStimulus(32'h114, 32'h0051_2423, 1'b1, eSw);     tick();
        applyStimulus(32'h118, 32'h4032_5193, 1'b1, eSrai);   tick();
        applyStimulus(32'h11C, 32'h0100_00EF, 1'b1, eJal);    tick();
        applyStimulus(32'h120, 32'h0000_0000, 1'b1, eZero);   tick();
        applyStimulus(32'h124, 32'h3020_0073, 1'b1, eMret);   tick();
        i_ce = 1'b0; tick();
        checkOutput("idle_ce", {31'b0, o_ce}, 32'd0);

        // Load-use hazard: lw x5 moves to execute while add x6,x5,x1 sits in decode.
        applyStimulus(32'h200, 32'h0040_A283, 1'b1, eLw);  tick();
        applyStimulus(32'h204, 32'h0012_8333, 1'b0, eNone); tick();
        i_ex_ce = 1'b1; i_ex_is_load = 1'b1; i_ex_rd = 5'd5;
        applyStimulus(32'h208, 32'h1234_53B7, 1'b0, eNone);
        #1;
        checkOutput("hazard_stall", {31'b0, o_stall}, 32'd1);
        tick();
        i_ex_ce = 1'b0; i_ex_is_load = 1'b0; i_ex_rd = 5'd0;
        #1;
        checkOutput("bubble_ce", {31'b0, o_ce}, 32'd0);
        checkOutput("bubble_stall", {31'b0, o_stall}, 32'd0);
        checkOutput("bubble_hold_rs1", {27'b0, o_rs1_addr}, 32'd5);
        applyStimulus(32'h204, 32'h0012_8333, 1'b1, eAdd); tick();
        checkOutput("reissue_ce", {31'b0, o_ce}, 32'd1);

        // Flush without a stall drops the incoming instruction.
        applyStimulus(32'h300, 32'h0051_2423, 1'b1, eSw); tick();
        i_flush = 1'b1;
        applyStimulus(32'h304, 32'h4032_5193, 1'b0, eNone); tick();
        checkOutput("flush_ce", {31'b0, o_ce}, 32'd0);
        i_flush = 1'b0;

        // Flush under a downstream stall is ignored and the register holds.
        applyStimulus(32'h308, 32'h0100_00EF, 1'b1, eJal); tick();
        i_stall = 1'b1; i_flush = 1'b1;
        applyStimulus(32'h30C, 32'hFE01_0113, 1'b0, eNone);
        #1;
        checkOutput("stall_req", {31'b0, o_stall}, 32'd1);
        tick();
        checkOutput("stall_hold_ce", {31'b0, o_ce}, 32'd1);
        checkOutput("stall_hold_pc", o_pc, 32'h308);
        checkOutput("stall_hold_rd", {27'b0, o_rd_addr}, 32'd1);
        i_stall = 1'b0; i_flush = 1'b0; i_ce = 1'b0;
        tick();
        checkOutput("post_stall_ce", {31'b0, o_ce}, 32'd0);

        // Asynchronous reset mid-stream drops the in-flight instruction immediately.
        applyStimulus(32'h400, 32'hFE01_0113, 1'b1, eAddi); tick();
        applyStimulus(32'h404, 32'h1234_53B7, 1'b0, eNone); tick();
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_ce", {31'b0, o_ce}, 32'd0);
        checkOutput("async_rst_pc", o_pc, 32'd0);
        checkOutput("async_rst_opcode", {21'b0, o_opcode}, 32'd0);
        checkOutput("async_rst_imm", o_imm, 32'd0);
        checkOutput("async_rst_rd", {27'b0, o_rd_addr}, 32'd0);
        applyStimulus(32'h408, 32'h0040_A283, 1'b0, eNone); tick();
        rst = 1'b0;
        applyStimulus(32'h40C, 32'hFE20_FEE3, 1'b1, eBgeu);
        #1;
        checkOutput("post_rst_idle", {31'b0, o_ce}, 32'd0);
        tick();
        checkOutput("post_rst_ce", {31'b0, o_ce}, 32'd1);
        checkOutput("post_rst_pc", o_pc, 32'h40C);

        i_ce = 1'b0;
        repeat (3) tick();
        checkOutput("sb_drained", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
